// File: rtl/scr1_vmem_portb_ctrl_pkg.sv
// Shared types for the port-B request sequencer of the dual-port vector data memory:
// vector word type, latched request record and sequencer state encoding.
package scr1_vmem_portb_ctrl_pkg;

   localparam int VMEM_WIDTH  = 32;
   localparam int VMEM_SIZE   = 32'h00010000;
   localparam int VMEM_NBYTES = VMEM_WIDTH / 8;
   localparam int LANE        = 4;
   localparam int VMEM_ADDR_W = $clog2(VMEM_SIZE);

   typedef logic [LANE-1:0][VMEM_WIDTH-1:0] type_vector;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RD_CAP = 2'd2,
      ST_RESP   = 2'd3
   } vmem_state_e;

   typedef struct packed {
      logic                   write;
      logic                   vector;
      logic [VMEM_ADDR_W-1:0] addr;
      logic [VMEM_NBYTES-1:0] be;
      type_vector             wdata;
   } vmem_req_t;

endpackage

// File: rtl/scr1_vmem_portb_ctrl_req_check.sv
// Combinational request checker: flags misaligned vectors, accesses running past the
// end of memory (no wrap-around) and scalar stores with no byte enabled.
module scr1_vmem_req_check
   import scr1_vmem_portb_ctrl_pkg::*;
#(
   parameter int SCR1_SIZE   = VMEM_SIZE,
   parameter int SCR1_NBYTES = VMEM_NBYTES
) (
   input  logic                         write,
   input  logic                         vector,
   input  logic [$clog2(SCR1_SIZE)-1:0] addr,
   input  logic [SCR1_NBYTES-1:0]       be,
   output logic                         err
);

   localparam int ADDR_W    = $clog2(SCR1_SIZE);
   localparam int RAM_WORDS = SCR1_SIZE / 4;

   logic [31:0] word_addr;
   logic [31:0] span_end;
   logic        misaligned;
   logic        out_of_range;
   logic        empty_store;

   always_comb begin
      word_addr    = 32'(addr[ADDR_W-1:2]);
      // One past the last word touched; must not exceed the memory depth.
      span_end     = word_addr + (vector ? 32'(LANE) : 32'd1);
      misaligned   = vector && (addr[1:0] != 2'b00);
      out_of_range = span_end > 32'(RAM_WORDS);
      empty_store  = write && !vector && (be == '0);
      err          = misaligned || out_of_range || empty_store;
   end

endmodule

// File: rtl/scr1_vmem_portb_ctrl.sv
// Port-B request sequencer: accepts one LSU load/store at a time, issues a single-cycle
// memory strobe, captures registered read data and returns a response with error status.
module scr1_vmem_portb_ctrl
   import scr1_vmem_portb_ctrl_pkg::*;
#(
   parameter int SCR1_WIDTH  = VMEM_WIDTH,
   parameter int SCR1_SIZE   = VMEM_SIZE,
   parameter int SCR1_NBYTES = SCR1_WIDTH / 8
) (
   input  logic                         clk,
   input  logic                         rst,
   // Both handshakes: a transfer happens on a rising clk edge where valid and ready are
   // both high; valid side holds its payload stable until that edge.
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic                         req_vector,
   input  logic [$clog2(SCR1_SIZE)-1:0] req_addr,
   input  logic [SCR1_NBYTES-1:0]       req_be,
   input  type_vector                   req_wdata,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic                         resp_err,
   output type_vector                   resp_rdata,
   output logic                         mem_renb,
   output logic                         mem_wenb,
   output logic [SCR1_NBYTES-1:0]       mem_webb,
   output logic                         mem_w_is_vector,
   output logic [$clog2(SCR1_SIZE)-3:0] mem_addrb,
   output type_vector                   mem_datab,
   input  type_vector                   mem_qb,
   output vmem_state_e                  dbg_state
);

   localparam int ADDR_W = $clog2(SCR1_SIZE);

   vmem_state_e state;
   vmem_req_t   req_q;
   vmem_req_t   req_in;
   logic        chk_err;
   logic        in_issue;
   type_vector  cap_data;

   scr1_vmem_req_check #(
      .SCR1_SIZE  (SCR1_SIZE),
      .SCR1_NBYTES(SCR1_NBYTES)
   ) u_req_check (
      .write (req_write),
      .vector(req_vector),
      .addr  (req_addr),
      .be    (req_be),
      .err   (chk_err)
   );

   always_comb begin
      req_in.write  = req_write;
      req_in.vector = req_vector;
      req_in.addr   = req_addr;
      req_in.be     = req_be;
      req_in.wdata  = req_wdata;
   end

   // Scalar loads return only element 0; the rest of the memory row is discarded.
   always_comb begin
      cap_data = '0;
      if (req_q.vector) begin
         cap_data = mem_qb;
      end else begin
         cap_data[0] = mem_qb[0];
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign dbg_state = state;
   assign in_issue  = (state == ST_ISSUE);

   // Strobes are decoded from the state register, so they are high for the ISSUE cycle
   // only and drop as soon as reset is asserted.
   assign mem_wenb        = in_issue && req_q.write;
   assign mem_renb        = in_issue && !req_q.write;
   assign mem_w_is_vector = in_issue && req_q.write && req_q.vector;
   assign mem_webb        = (in_issue && req_q.write) ? (req_q.vector ? '1 : req_q.be) : '0;
   assign mem_addrb       = in_issue ? req_q.addr[ADDR_W-1:2] : '0;
   assign mem_datab       = (in_issue && req_q.write) ? req_q.wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q <= req_in;
                  if (chk_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (req_q.write) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
               end else begin
                  state <= ST_RD_CAP;
               end
            end
            ST_RD_CAP: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= cap_data;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/scr1_vmem_portb_ctrl.md
Name: scr1_vmem_portb_ctrl

Overview:
Request sequencer that sits directly upstream of port B of the dual-port vector data memory and owns it exclusively. Accepts one scalar or LANE-wide vector load/store from the core-side LSU over a valid/ready handshake. Drives the memory strobes (renb/wenb/webb/w_is_vector/addrb/datab) and captures the registered read data. Returns a response over a valid/ready handshake, with range/alignment checking.

Parameters:
SCR1_WIDTH, 32, word width in bits; memory data is LANE words of this width.
SCR1_SIZE, 32'h00010000, memory size in bytes; RAM_WORDS = SCR1_SIZE/4.
SCR1_NBYTES, SCR1_WIDTH/8, byte enables per word.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=store, 0=load
req_vector  in  1  1=LANE-word vector access, 0=scalar word
req_addr  in  $clog2(SCR1_SIZE)  byte address
req_be  in  SCR1_NBYTES  scalar store byte enables (ignored for vector and loads)
req_wdata  in  type_vector  store data; scalar uses element 0
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when valid&ready
resp_err  out  1  request rejected, no memory access made
resp_rdata  out  type_vector  load data; scalar in element 0, others zero
mem_renb  out  1  port B read strobe
mem_wenb  out  1  port B write strobe
mem_webb  out  SCR1_NBYTES  port B byte enables
mem_w_is_vector  out  1  port B vector write select
mem_addrb  out  $clog2(SCR1_SIZE)-2  port B word address
mem_datab  out  type_vector  port B write data
mem_qb  in  type_vector  port B read data, valid the cycle after renb

Behaviour:
- States: IDLE, ISSUE, RD_CAP, RESP. req_ready = (state==IDLE); a single request is outstanding at a time.
- Accept in cycle T latches write/vector/addr/be/wdata into request registers.
- Error check at accept:
  - vector with addr[1:0]!=0 -> err.
  - word address + (vector ? LANE : 1) > RAM_WORDS -> err.
  - scalar store with be==0 -> err.
  - Err: go to RESP at T+1 with resp_err=1, rdata=0, no strobe ever asserted.
- ISSUE (T+1):
  - mem_addrb = latched addr[..:2].
  - Store: wenb=1, w_is_vector=vector, webb = vector ? all ones : be, datab = latched wdata.
  - Load: renb=1.
  - Strobes are high for exactly this one cycle and are 0/all-zero in every other state.
  - Store goes to RESP at T+2. Load goes to RD_CAP.
- RD_CAP (T+2): rdata register <= mem_qb; scalar zeroes elements 1..LANE-1. Next state RESP, so the load response is at T+3.
- RESP: resp_valid=1, holding err and rdata stable until resp_ready. On valid&ready return to IDLE; the next accept is possible the following cycle. Throughput is one request per 3 cycles (store) or 4 cycles (load) with resp_ready tied high.
- Store response: resp_err=0, resp_rdata holds its previous value.
- No wrap-around: last legal vector word address is RAM_WORDS-LANE.
- Reset (async, any state):
  - state=IDLE, req_ready=1 after reset.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - All mem_* outputs 0.
  - A store in ISSUE when reset asserts is dropped; no partial-write guarantee beyond what the memory already sampled.
- req inputs are ignored when not in IDLE.

Decomposition:
- Shared package (existing defines): LANE, type_vector (LANE x SCR1_WIDTH), plus a new request struct type (write, vector, addr, be, wdata) and state enum.
- One natural sub-module: scr1_vmem_req_check (combinational range/alignment/be checker returning err). Everything else in the top.

Test Plan:
- Scalar store addr=0x10, be=4'b0101, wdata[0]=0xAABBCCDD -> T+1 wenb=1, webb=0101, addrb=4, w_is_vector=0; resp T+2, err=0.
- Vector store addr=0x40, then vector load 0x40 -> load resp at accept+3, rdata equals written LANE words; renb high exactly one cycle.
- Scalar load after the first store -> rdata[0]=0x00BB00DD (prior zero memory), elements 1..LANE-1 = 0.
- Vector load addr=0x42 -> err=1 at T+1, no strobes. Vector at word RAM_WORDS-LANE+1 -> err. Word RAM_WORDS-LANE -> ok.
- resp_ready held low 5 cycles -> resp_valid/rdata stable, req_ready=0; new req_valid is ignored.
- Assert rst during ISSUE of a store -> mem_wenb=0 and resp_valid=0 same cycle; req_ready=1 after release.
